// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller and the forwarding logic.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_BUSY  = 2'd1,
    MEM_WAIT = 2'd2
  } phc_state_t;

  localparam int unsigned REG_ZERO = 0;

  // Operand forwarding mux selects
  localparam logic [1:0] FWD_NONE  = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

endpackage

// File: rtl/hazard_stats_counter.sv
// Saturating event counter used for hazard statistics.
module hazard_stats_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: load-use, redirect, mul/div and dmem waits.
// Optional statistics counters are built when PHC_STATS_EN is defined.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] idRs1,
  input  logic [REG_AW-1:0] idRs2,
  input  logic              idUseRs1,
  input  logic              idUseRs2,
  input  logic [REG_AW-1:0] idExRd,
  input  logic              idExMemRead,
  input  logic              exRedirect,
  input  logic              mdStart,
  input  logic              mdDone,
  input  logic              memReq,
  input  logic              memReady,
  output logic              pcWe,
  output logic              ifIdWe,
  output logic              idExWe,
  output logic              exMemWe,
  output logic              memWbWe,
  output logic              ifIdFlush,
  output logic              idExFlush,
  output logic              exMemFlush,
  output logic              memWbFlush,
  output logic [CNT_W-1:0]  stallCnt,
  output logic [CNT_W-1:0]  flushCnt
);

  phc_state_t r_state;
  phc_state_t w_state_nxt;
  logic       r_md_pend;
  logic       w_md_pend_nxt;
  logic       r_md_seen;
  logic       w_md_seen_nxt;
  logic       w_mem_stall;
  logic       w_load_use;
  logic       w_redirect_taken;

  assign w_mem_stall = memReq & ~memReady;
  assign w_load_use  = idExMemRead && (idExRd != REG_AW'(REG_ZERO)) &&
                       ((idUseRs1 && (idRs1 == idExRd)) || (idUseRs2 && (idRs2 == idExRd)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RUN;
      r_md_pend <= 1'b0;
      r_md_seen <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_md_pend <= w_md_pend_nxt;
      r_md_seen <= w_md_seen_nxt;
    end
  end

  // Next state and per-stage enables/flushes; r_md_pend marks a mul/div op parked behind a memory wait
  always_comb begin
    w_state_nxt      = r_state;
    w_md_pend_nxt    = r_md_pend;
    w_md_seen_nxt    = r_md_seen;
    w_redirect_taken = 1'b0;
    pcWe             = 1'b1;
    ifIdWe           = 1'b1;
    idExWe           = 1'b1;
    exMemWe          = 1'b1;
    memWbWe          = 1'b1;
    ifIdFlush        = 1'b0;
    idExFlush        = 1'b0;
    exMemFlush       = 1'b0;
    memWbFlush       = 1'b0;

    unique case (r_state)
      RUN: begin
        if (w_mem_stall) begin
          {pcWe, ifIdWe, idExWe, exMemWe, memWbWe} = 5'b00000;
          memWbFlush    = 1'b1;
          w_md_pend_nxt = mdStart;
          w_state_nxt   = MEM_WAIT;
        end else if (mdStart) begin
          {pcWe, ifIdWe, idExWe} = 3'b000;
          exMemFlush  = 1'b1;
          w_state_nxt = MD_BUSY;
        end else if (exRedirect) begin
          ifIdFlush        = 1'b1;
          idExFlush        = 1'b1;
          w_redirect_taken = 1'b1;
        end else if (w_load_use) begin
          {pcWe, ifIdWe} = 2'b00;
          idExFlush      = 1'b1;
        end
      end
      MD_BUSY: begin
        if (w_mem_stall) begin
          {pcWe, ifIdWe, idExWe, exMemWe, memWbWe} = 5'b00000;
          memWbFlush    = 1'b1;
          w_md_pend_nxt = 1'b1;
          w_md_seen_nxt = mdDone;
          w_state_nxt   = MEM_WAIT;
        end else if (mdDone) begin
          w_md_pend_nxt = 1'b0;
          w_state_nxt   = RUN;
        end else begin
          {pcWe, ifIdWe, idExWe} = 3'b000;
          exMemFlush = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (w_mem_stall) begin
          {pcWe, ifIdWe, idExWe, exMemWe, memWbWe} = 5'b00000;
          memWbFlush = 1'b1;
          if (mdDone) w_md_seen_nxt = 1'b1;
        end else begin
          // A done pulse coinciding with memReady also completes the op
          w_md_seen_nxt = 1'b0;
          if (r_md_pend && !(r_md_seen || mdDone)) begin
            w_state_nxt = MD_BUSY;
          end else begin
            w_md_pend_nxt = 1'b0;
            w_state_nxt   = RUN;
          end
        end
      end
      default: begin
        w_state_nxt   = RUN;
        w_md_pend_nxt = 1'b0;
        w_md_seen_nxt = 1'b0;
      end
    endcase

    if (!rst_n) begin
      {pcWe, ifIdWe, idExWe, exMemWe, memWbWe}         = 5'b00000;
      {ifIdFlush, idExFlush, exMemFlush, memWbFlush}   = 4'b1111;
    end
  end

  // A new mul/div may only enter EX while the pipeline runs freely
  a_md_start_in_run: assert property (@(posedge clk) disable iff (!rst_n)
    mdStart |-> (r_state == RUN));

`ifdef PHC_STATS_EN
  hazard_stats_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (~pcWe),
    .o_cnt (stallCnt)
  );

  hazard_stats_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_redirect_taken),
    .o_cnt (flushCnt)
  );
`else
  assign stallCnt = '0;
  assign flushCnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed and randomized checks of pipeline_hazard_ctrl against a behavioural pipeline model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 32;
`ifdef PHC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // {pcWe,ifIdWe,idExWe,exMemWe,memWbWe, ifIdFlush,idExFlush,exMemFlush,memWbFlush}
  localparam logic [8:0] V_GO     = 9'b11111_0000;
  localparam logic [8:0] V_FROZEN = 9'b00000_0001;
  localparam logic [8:0] V_MDHOLD = 9'b00011_0010;
  localparam logic [8:0] V_REDIR  = 9'b11111_1100;
  localparam logic [8:0] V_BUBBLE = 9'b00111_0100;
  localparam logic [8:0] V_RESET  = 9'b00000_1111;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [REG_AW-1:0] idRs1, idRs2, idExRd;
  logic              idUseRs1, idUseRs2, idExMemRead;
  logic              exRedirect, mdStart, mdDone, memReq, memReady;
  logic              pcWe, ifIdWe, idExWe, exMemWe, memWbWe;
  logic              ifIdFlush, idExFlush, exMemFlush, memWbFlush;
  logic [CNT_W-1:0]  stallCnt, flushCnt;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: what the pipeline is doing, not how the controller encodes it
  bit          m_md_busy;     // mul/div op occupies EX and has not finished
  bit          m_done_early;  // its result arrived while memory was stalled
  bit          m_mem_hold;    // previous cycle was frozen on data memory
  logic [31:0] m_stall;
  logic [31:0] m_flush;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .idRs1      (idRs1),
    .idRs2      (idRs2),
    .idUseRs1   (idUseRs1),
    .idUseRs2   (idUseRs2),
    .idExRd     (idExRd),
    .idExMemRead(idExMemRead),
    .exRedirect (exRedirect),
    .mdStart    (mdStart),
    .mdDone     (mdDone),
    .memReq     (memReq),
    .memReady   (memReady),
    .pcWe       (pcWe),
    .ifIdWe     (ifIdWe),
    .idExWe     (idExWe),
    .exMemWe    (exMemWe),
    .memWbWe    (memWbWe),
    .ifIdFlush  (ifIdFlush),
    .idExFlush  (idExFlush),
    .exMemFlush (exMemFlush),
    .memWbFlush (memWbFlush),
    .stallCnt   (stallCnt),
    .flushCnt   (flushCnt)
  );

  task automatic clr();
    idRs1 = '0; idRs2 = '0; idExRd = '0;
    idUseRs1 = 1'b0; idUseRs2 = 1'b0; idExMemRead = 1'b0;
    exRedirect = 1'b0; mdStart = 1'b0; mdDone = 1'b0;
    memReq = 1'b0; memReady = 1'b1;
  endtask

  // Check one cycle at the falling edge, advance the model, then move past the rising edge
  task automatic step(input string tag);
    logic [8:0]       exp_v;
    logic [8:0]       obs_v;
    logic [CNT_W-1:0] exp_s, exp_f;
    bit               ms, lu, redir;
    @(negedge clk);
    #1;
    exp_s = STATS ? CNT_W'(m_stall) : '0;
    exp_f = STATS ? CNT_W'(m_flush) : '0;
    checks++;
    assert (stallCnt === exp_s) else begin
      failures++;
      $error("FAIL %s stallCnt obs=%0d exp=%0d", tag, stallCnt, exp_s);
    end
    checks++;
    assert (flushCnt === exp_f) else begin
      failures++;
      $error("FAIL %s flushCnt obs=%0d exp=%0d", tag, flushCnt, exp_f);
    end

    ms    = memReq && !memReady;
    lu    = idExMemRead && (idExRd != 0) &&
            ((idUseRs1 && idRs1 == idExRd) || (idUseRs2 && idRs2 == idExRd));
    redir = 1'b0;
    exp_v = V_GO;
    if (!rst_n) begin
      exp_v = V_RESET;
      m_md_busy = 0; m_done_early = 0; m_mem_hold = 0;
      m_stall = '0; m_flush = '0;
    end else if (ms) begin
      exp_v = V_FROZEN;
      if (!m_mem_hold && !m_md_busy && mdStart) m_md_busy = 1;
      else if (m_md_busy && mdDone) m_done_early = 1;
      m_mem_hold = 1;
    end else if (m_mem_hold) begin
      m_mem_hold = 0;
      if (m_md_busy && (m_done_early || mdDone)) m_md_busy = 0;
      m_done_early = 0;
    end else if (m_md_busy) begin
      if (mdDone) m_md_busy = 0;
      else exp_v = V_MDHOLD;
    end else if (mdStart) begin
      exp_v = V_MDHOLD;
      m_md_busy = 1;
    end else if (exRedirect) begin
      exp_v = V_REDIR;
      redir = 1'b1;
    end else if (lu) begin
      exp_v = V_BUBBLE;
    end

    obs_v = {pcWe, ifIdWe, idExWe, exMemWe, memWbWe,
             ifIdFlush, idExFlush, exMemFlush, memWbFlush};
    checks++;
    assert (obs_v === exp_v) else begin
      failures++;
      $error("FAIL %s ctrl obs=%b exp=%b", tag, obs_v, exp_v);
    end

    if (rst_n) begin
      if (!exp_v[8]) m_stall = m_stall + 1;
      if (redir)     m_flush = m_flush + 1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    m_md_busy = 0; m_done_early = 0; m_mem_hold = 0;
    m_stall = '0; m_flush = '0;
    step("reset");
    rst_n = 1'b1;
    step("run_idle");

    // Load x5 in EX, ID reads x5: one bubble then free
    idExMemRead = 1'b1; idExRd = 5'd5; idRs1 = 5'd5; idUseRs1 = 1'b1;
    step("lu_x5");
    clr();
    step("lu_after");

    // Load to x0 never stalls
    idExMemRead = 1'b1; idExRd = 5'd0; idRs1 = 5'd0; idRs2 = 5'd0;
    idUseRs1 = 1'b1; idUseRs2 = 1'b1;
    step("lu_x0");

    // Redirect beats load-use on rs2
    clr();
    idExMemRead = 1'b1; idExRd = 5'd9; idRs2 = 5'd9; idUseRs2 = 1'b1; exRedirect = 1'b1;
    step("redir_lu");
    clr();
    step("redir_after");

    // mul/div: start, four busy cycles, done
    mdStart = 1'b1;
    step("md_start");
    clr();
    for (int i = 0; i < 4; i++) step("md_busy");
    mdDone = 1'b1;
    step("md_done");
    clr();
    step("md_after");

    // Memory stall during MD_BUSY with done latched in the middle
    mdStart = 1'b1;
    step("mw_start");
    clr();
    step("mw_busy");
    memReq = 1'b1; memReady = 1'b0;
    step("mw_stall1");
    mdDone = 1'b1;
    step("mw_stall2");
    mdDone = 1'b0;
    step("mw_stall3");
    memReady = 1'b1;
    step("mw_ready");
    clr();
    step("mw_run");

    // Reset in the middle of a memory wait
    exRedirect = 1'b1;
    step("pre_rst_redir");
    clr();
    memReq = 1'b1; memReady = 1'b0;
    step("rst_stall1");
    step("rst_stall2");
    rst_n = 1'b0;
    step("rst_mid");
    rst_n = 1'b1;
    clr();
    step("rst_release");

    // Randomized traffic; mul/div pulses only where the protocol allows them
    for (int n = 0; n < 400; n++) begin
      idRs1       = REG_AW'($urandom_range(0, 7));
      idRs2       = REG_AW'($urandom_range(0, 7));
      idExRd      = REG_AW'($urandom_range(0, 7));
      idUseRs1    = 1'($urandom_range(0, 1));
      idUseRs2    = 1'($urandom_range(0, 1));
      idExMemRead = 1'($urandom_range(0, 1));
      exRedirect  = ($urandom_range(0, 5) == 0);
      memReq      = ($urandom_range(0, 2) == 0);
      memReady    = 1'($urandom_range(0, 1));
      mdStart     = !m_md_busy && !m_mem_hold && ($urandom_range(0, 7) == 0);
      mdDone      = m_md_busy && !m_done_early && ($urandom_range(0, 3) == 0);
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
